// File: rtl/uart_apb_tx_scheduler_if.sv
// Bus bundle between the UART TX scheduler and its surroundings: the APB link
// to the UART slave, the two byte requesters and the receive/config side outputs.
interface uart_apb_tx_scheduler_if;
  logic [4:0] M_PADDR;
  logic       M_PSEL;
  logic       M_PENABLE;
  logic       M_PWRITE;
  logic [7:0] M_PWDATA;
  logic [7:0] M_PRDATA;
  logic       M_PREADY;
  logic       REQ0_VALID;
  logic [7:0] REQ0_DATA;
  logic       REQ0_READY;
  logic       REQ1_VALID;
  logic [7:0] REQ1_DATA;
  logic       REQ1_READY;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic [2:0] RX_ERR;
  logic       CFG_DONE;

  modport master (
    output M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
    input  M_PRDATA, M_PREADY,
    input  REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA,
    output REQ0_READY, REQ1_READY,
    output RX_VALID, RX_DATA, RX_ERR, CFG_DONE
  );

  modport slave (
    input  M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
    output M_PRDATA, M_PREADY,
    output REQ0_VALID, REQ0_DATA, REQ1_VALID, REQ1_DATA,
    input  REQ0_READY, REQ1_READY,
    input  RX_VALID, RX_DATA, RX_ERR, CFG_DONE
  );
endinterface

// File: rtl/uart_apb_tx_scheduler.sv
// APB master owning one CoreUARTapb: configures it, polls status, drains RX bytes
// and shares the transmitter between two requesters with round-robin arbitration.
module uart_apb_tx_scheduler #(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic [2:0]  FORMAT     = 3'b001,
  parameter logic [2:0]  BAUD_FRAC  = 3'b000
) (
  input logic                      PCLK,
  input logic                      PRESET,
  uart_apb_tx_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    ST_CFG1 = 3'd0,
    ST_CFG2 = 3'd1,
    ST_CFG3 = 3'd2,
    ST_POLL = 3'd3,
    ST_RDRX = 3'd4,
    ST_WRTX = 3'd5
  } state_t;

  // phase_r names the bus cycle currently presented on the APB outputs
  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_ACCESS = 2'd1,
    PH_IDLE   = 2'd2
  } phase_t;

  state_t     state_r, state_nx_s;
  phase_t     phase_r, phase_nx_s;

  logic       ptr_r, ptr_nx_s;
  logic [7:0] tx_hold_r, tx_hold_nx_s;
  logic [2:0] err_r, err_nx_s;
  logic       cfg_done_r, cfg_done_nx_s;
  logic [4:0] paddr_r, paddr_nx_s;
  logic       psel_r, psel_nx_s;
  logic       penable_r, penable_nx_s;
  logic       pwrite_r, pwrite_nx_s;
  logic [7:0] pwdata_r, pwdata_nx_s;
  logic       req0_ready_r, req0_ready_nx_s;
  logic       req1_ready_r, req1_ready_nx_s;
  logic       rx_valid_r, rx_valid_nx_s;
  logic [7:0] rx_data_r, rx_data_nx_s;
  logic [2:0] rx_err_r, rx_err_nx_s;

  logic [4:0] desc_addr_s;
  logic       desc_write_s;
  logic [7:0] desc_wdata_s;

  logic       xfer_done_s;
  logic       poll_done_s;
  logic       tx_slot_s;
  logic       both_valid_s;
  logic       gnt0_s;
  logic       gnt1_s;
  logic [2:0] prdata_unused_s;

  assign xfer_done_s     = (phase_r == PH_ACCESS) && bus.M_PREADY;
  assign poll_done_s     = xfer_done_s && (state_r == ST_POLL);
  // a TX slot exists only when no byte is waiting and the transmitter is ready
  assign tx_slot_s       = poll_done_s && !bus.M_PRDATA[1] && bus.M_PRDATA[0];
  assign both_valid_s    = bus.REQ0_VALID && bus.REQ1_VALID;
  assign gnt0_s          = tx_slot_s && bus.REQ0_VALID && (!bus.REQ1_VALID || ptr_r);
  assign gnt1_s          = tx_slot_s && bus.REQ1_VALID && (!bus.REQ0_VALID || !ptr_r);
  assign prdata_unused_s = bus.M_PRDATA[7:5];

  // State and bus-phase register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= ST_CFG1;
      phase_r <= PH_IDLE;
    end else begin
      state_r <= state_nx_s;
      phase_r <= phase_nx_s;
    end
  end

  // Next-state logic: bus phase sequencing and transfer-to-transfer decisions
  always_comb begin
    state_nx_s = state_r;
    phase_nx_s = phase_r;
    case (phase_r)
      PH_IDLE:   phase_nx_s = PH_SETUP;
      PH_SETUP:  phase_nx_s = PH_ACCESS;
      PH_ACCESS: phase_nx_s = bus.M_PREADY ? PH_IDLE : PH_ACCESS;
      default:   phase_nx_s = PH_IDLE;
    endcase
    if (xfer_done_s) begin
      case (state_r)
        ST_CFG1: state_nx_s = ST_CFG2;
        ST_CFG2: state_nx_s = ST_CFG3;
        ST_CFG3: state_nx_s = ST_POLL;
        ST_POLL: begin
          if (bus.M_PRDATA[1]) begin
            state_nx_s = ST_RDRX;
          end else if (gnt0_s || gnt1_s) begin
            state_nx_s = ST_WRTX;
          end else begin
            state_nx_s = ST_POLL;
          end
        end
        ST_RDRX: state_nx_s = ST_POLL;
        ST_WRTX: state_nx_s = ST_POLL;
        default: state_nx_s = ST_CFG1;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Transfer descriptor for the APB access owned by the current state
  always_comb begin
    desc_addr_s  = 5'h00;
    desc_write_s = 1'b0;
    desc_wdata_s = 8'h00;
    case (state_r)
      ST_CFG1: begin
        desc_addr_s  = 5'h08;
        desc_write_s = 1'b1;
        desc_wdata_s = BAUD_VALUE[7:0];
      end
      ST_CFG2: begin
        desc_addr_s  = 5'h0C;
        desc_write_s = 1'b1;
        desc_wdata_s = {BAUD_VALUE[12:8], FORMAT};
      end
      ST_CFG3: begin
        desc_addr_s  = 5'h14;
        desc_write_s = 1'b1;
        desc_wdata_s = {5'b00000, BAUD_FRAC};
      end
      ST_POLL: desc_addr_s = 5'h10;
      ST_RDRX: desc_addr_s = 5'h04;
      ST_WRTX: begin
        desc_addr_s  = 5'h00;
        desc_write_s = 1'b1;
        desc_wdata_s = tx_hold_r;
      end
      default: desc_addr_s = 5'h00;
    endcase
  end

  // Output logic: next values of the registered bus, handshake and datapath outputs
  always_comb begin
    paddr_nx_s      = paddr_r;
    psel_nx_s       = psel_r;
    penable_nx_s    = penable_r;
    pwrite_nx_s     = pwrite_r;
    pwdata_nx_s     = pwdata_r;
    ptr_nx_s        = ptr_r;
    tx_hold_nx_s    = tx_hold_r;
    err_nx_s        = err_r;
    cfg_done_nx_s   = cfg_done_r;
    rx_data_nx_s    = rx_data_r;
    rx_err_nx_s     = rx_err_r;
    rx_valid_nx_s   = 1'b0;
    req0_ready_nx_s = gnt0_s;
    req1_ready_nx_s = gnt1_s;
    case (phase_r)
      PH_IDLE: begin
        psel_nx_s    = 1'b1;
        penable_nx_s = 1'b0;
        paddr_nx_s   = desc_addr_s;
        pwrite_nx_s  = desc_write_s;
        pwdata_nx_s  = desc_wdata_s;
      end
      PH_SETUP:  penable_nx_s = 1'b1;
      PH_ACCESS: begin
        psel_nx_s    = !bus.M_PREADY;
        penable_nx_s = !bus.M_PREADY;
      end
      default: begin
        psel_nx_s    = 1'b0;
        penable_nx_s = 1'b0;
      end
    endcase
    if (xfer_done_s) begin
      case (state_r)
        ST_CFG3: cfg_done_nx_s = 1'b1;
        ST_POLL: begin
          err_nx_s     = bus.M_PRDATA[1] ? bus.M_PRDATA[4:2] : err_r;
          tx_hold_nx_s = gnt0_s ? bus.REQ0_DATA : (gnt1_s ? bus.REQ1_DATA : tx_hold_r);
          ptr_nx_s     = (both_valid_s && tx_slot_s) ? gnt1_s : ptr_r;
        end
        ST_RDRX: begin
          rx_data_nx_s  = bus.M_PRDATA;
          rx_err_nx_s   = err_r;
          rx_valid_nx_s = 1'b1;
        end
        default: cfg_done_nx_s = cfg_done_r;
      endcase
    end else begin
      cfg_done_nx_s = cfg_done_r;
    end
  end

  // Registered outputs and datapath; reset discards any held TX byte
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      paddr_r      <= 5'h00;
      psel_r       <= 1'b0;
      penable_r    <= 1'b0;
      pwrite_r     <= 1'b0;
      pwdata_r     <= 8'h00;
      ptr_r        <= 1'b1;
      tx_hold_r    <= 8'h00;
      err_r        <= 3'b000;
      cfg_done_r   <= 1'b0;
      rx_data_r    <= 8'h00;
      rx_err_r     <= 3'b000;
      rx_valid_r   <= 1'b0;
      req0_ready_r <= 1'b0;
      req1_ready_r <= 1'b0;
    end else begin
      paddr_r      <= paddr_nx_s;
      psel_r       <= psel_nx_s;
      penable_r    <= penable_nx_s;
      pwrite_r     <= pwrite_nx_s;
      pwdata_r     <= pwdata_nx_s;
      ptr_r        <= ptr_nx_s;
      tx_hold_r    <= tx_hold_nx_s;
      err_r        <= err_nx_s;
      cfg_done_r   <= cfg_done_nx_s;
      rx_data_r    <= rx_data_nx_s;
      rx_err_r     <= rx_err_nx_s;
      rx_valid_r   <= rx_valid_nx_s;
      req0_ready_r <= req0_ready_nx_s;
      req1_ready_r <= req1_ready_nx_s;
    end
  end

  assign bus.M_PADDR    = paddr_r;
  assign bus.M_PSEL     = psel_r;
  assign bus.M_PENABLE  = penable_r;
  assign bus.M_PWRITE   = pwrite_r;
  assign bus.M_PWDATA   = pwdata_r;
  assign bus.REQ0_READY = req0_ready_r;
  assign bus.REQ1_READY = req1_ready_r;
  assign bus.RX_VALID   = rx_valid_r;
  assign bus.RX_DATA    = rx_data_r;
  assign bus.RX_ERR     = rx_err_r;
  assign bus.CFG_DONE   = cfg_done_r;

endmodule
